key_rate_ctrl: RTL and testbench
================================

KEY_RATE_CTRL -- requirements
Module: key_rate_ctrl

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 25000000: hold cycles (key continuously pressed) that qualify a long press; legal range 2..2^32-1.
REQ-002 SHALL have parameters DIV0/DIV1/DIV2/DIV3, defaults 25000000/12500000/5000000/2500000: tick period in clk cycles for rate_sel 0..3; legal range 2..2^32-1.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port key_state  input  1  debounced key level from the debouncer, 1 = pressed, synchronous to clk.
REQ-006 SHALL have port press_pulse  output  1  one-cycle strobe on key press.
REQ-007 SHALL have port release_pulse  output  1  one-cycle strobe on key release.
REQ-008 SHALL have port long_pulse  output  1  one-cycle strobe when a press qualifies as long.
REQ-009 SHALL have port rate_sel  output  2  currently selected rate index.
REQ-010 SHALL have port tick  output  1  one-cycle strobe at the selected period.
REQ-011 SHALL have port led  output  1  toggles on every tick.

Function
REQ-012 SHALL keep a registered copy key_d of key_state; all outputs registered.
REQ-013 SHALL assert press_pulse for exactly one cycle, on the edge after the one where key_state=1 and key_d=0 are sampled; release_pulse likewise for key_state=0, key_d=1.
REQ-014 SHALL implement FSM IDLE, PRESSED, HELD with a 32-bit hold counter.
REQ-015 IDLE: key_state=1 -> PRESSED, hold counter cleared to 0; otherwise stay.
REQ-016 PRESSED: key_state=0 -> IDLE and rate_sel <= rate_sel+1 modulo 4 (3 wraps to 0) (short press); else hold counter increments.
REQ-017 PRESSED: key_state=1 with hold counter = LONG_CYCLES-1 -> HELD, long_pulse for one cycle, rate_sel <= 0.
REQ-018 Release in the same cycle the counter reaches LONG_CYCLES-1: release wins, short-press action, no long_pulse.
REQ-019 HELD: key_state=0 -> IDLE, rate_sel unchanged; hold counter frozen while HELD.
REQ-020 SHALL run a 32-bit tick counter; when counter = DIVn-1 (n = rate_sel) assert tick one cycle and wrap counter to 0, else increment.
REQ-021 Any change of rate_sel (short or long press) SHALL clear the tick counter to 0 on the same edge and suppress tick that cycle; first tick at new rate exactly DIVn cycles later.
REQ-022 A long press with rate_sel already 0 SHALL still clear the tick counter.
REQ-023 led SHALL invert on every edge where tick is asserted; never otherwise.
REQ-024 press_pulse, release_pulse, long_pulse SHALL be mutually independent of tick; may coincide.

Reset
REQ-025 rst_n=0 SHALL immediately force: FSM IDLE, key_d 0, hold and tick counters 0, rate_sel 0, all pulses 0, tick 0, led 0.
REQ-026 Reset asserted mid-press SHALL abandon the press; if key_state=1 at deassertion, press_pulse fires on the first following edge with rate_sel still 0.

Verification (LONG_CYCLES=8, DIV0=4, DIV1=6, DIV2=8, DIV3=10)
REQ-027 Idle after reset, key_state=0 for 40 cycles -> tick every 4 cycles, first 4 cycles after reset release, led toggles each tick, rate_sel=0.
REQ-028 Press 3 cycles then release -> press_pulse and release_pulse once each, rate_sel=1, next tick 6 cycles after the change; four such presses -> rate_sel returns to 0.
REQ-029 rate_sel=2, hold 20 cycles -> long_pulse once, 8 cycles after entering PRESSED, rate_sel=0, no change on release, release_pulse once.
REQ-030 Release on exact cycle counter reaches 7 -> no long_pulse, rate_sel increments.
REQ-031 Pull rst_n low mid-hold at rate_sel=3 with led=1 -> all outputs 0 asynchronously; key still high at release -> press_pulse next edge.

Source files
------------

// File: rtl/key_rate_ctrl.sv
// Key press classifier (short/long) that steps a rate selector and drives a
// divided tick strobe plus an LED that toggles on each tick.
module key_rate_ctrl #(
  parameter int unsigned LONG_CYCLES = 25000000,
  parameter int unsigned DIV0        = 25000000,
  parameter int unsigned DIV1        = 12500000,
  parameter int unsigned DIV2        = 5000000,
  parameter int unsigned DIV3        = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_state,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [1:0] rate_sel,
  output logic       tick,
  output logic       led
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] div_sel;
  logic [1:0]       rate_d;
  logic             long_d;
  logic             tick_d;
  logic             rate_change;
  logic             key_d;

  // Tick period for the currently selected rate
  always_comb begin
    case (rate_sel)
      2'd0:    div_sel = CNT_W'(DIV0);
      2'd1:    div_sel = CNT_W'(DIV1);
      2'd2:    div_sel = CNT_W'(DIV2);
      default: div_sel = CNT_W'(DIV3);
    endcase
  end

  // Press classification; a release always beats the long-press threshold
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    rate_d      = rate_sel;
    long_d      = 1'b0;
    rate_change = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_state) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (!key_state) begin
          state_d     = IDLE;
          rate_d      = rate_sel + 2'd1;
          rate_change = 1'b1;
        end else if (hold_q == CNT_W'(LONG_CYCLES - 32'd1)) begin
          state_d     = HELD;
          long_d      = 1'b1;
          rate_d      = 2'd0;
          rate_change = 1'b1;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_state) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Any rate update restarts the period so the first tick lands a full period later
  always_comb begin
    tick_d     = 1'b0;
    tick_cnt_d = tick_cnt_q + CNT_W'(1);
    if (rate_change) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == div_sel - CNT_W'(1)) begin
      tick_d     = 1'b1;
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      tick_cnt_q    <= '0;
      key_d         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      rate_sel      <= 2'd0;
      tick          <= 1'b0;
      led           <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      tick_cnt_q    <= tick_cnt_d;
      key_d         <= key_state;
      press_pulse   <= key_state & ~key_d;
      release_pulse <= ~key_state & key_d;
      long_pulse    <= long_d;
      rate_sel      <= rate_d;
      tick          <= tick_d;
      led           <= led ^ tick_d;
    end
  end

endmodule

// File: tb/tb_key_rate_ctrl.sv
// Self-checking bench for key_rate_ctrl: cycle scoreboard, press vector table,
// and hand sequences for tick restart and asynchronous reset.
module tb_key_rate_ctrl;

  localparam int unsigned LONG = 8;
  localparam int unsigned D0 = 4, D1 = 6, D2 = 8, D3 = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_state = 1'b0;
  logic       press_pulse, release_pulse, long_pulse, tick, led;
  logic [1:0] rate_sel;

  key_rate_ctrl #(
    .LONG_CYCLES(LONG), .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_state(key_state),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .rate_sel(rate_sel), .tick(tick), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       prs;
    logic       rel;
    logic       lng;
    logic [1:0] rate;
    logic       tck;
    logic       led;
  } exp_t;

  typedef struct {
    int         press_len;
    logic [1:0] exp_rate;
    int         exp_long;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic       m_key_d;
  int         m_state;   // 0 idle, 1 pressed, 2 held
  int         m_hold;
  logic [1:0] m_rate;
  int         m_tcnt;
  logic       m_led;

  // Observed pulse tallies
  int n_press, n_rel, n_long, n_tick;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] r);
    case (r)
      2'd0: return int'(D0);
      2'd1: return int'(D1);
      2'd2: return int'(D2);
      default: return int'(D3);
    endcase
  endfunction

  task automatic model_reset();
    m_key_d = 1'b0; m_state = 0; m_hold = 0; m_rate = 2'd0; m_tcnt = 0; m_led = 1'b0;
  endtask

  // Advance the model one edge with key level k and return expected outputs
  task automatic model_step(input logic k, output exp_t e);
    logic shrt, lng;
    shrt = 1'b0; lng = 1'b0;
    e = '0;
    e.prs = k && !m_key_d;
    e.rel = !k && m_key_d;
    m_key_d = k;
    if (m_state == 0) begin
      if (k) begin m_state = 1; m_hold = 0; end
    end else if (m_state == 1) begin
      if (!k) begin m_state = 0; shrt = 1'b1; end
      else if (m_hold == int'(LONG) - 1) begin m_state = 2; lng = 1'b1; end
      else m_hold = m_hold + 1;
    end else if (!k) begin
      m_state = 0;
    end
    if (shrt || lng) begin
      m_tcnt = 0;
      m_rate = lng ? 2'd0 : m_rate + 2'd1;
    end else if (m_tcnt == div_of(m_rate) - 1) begin
      m_tcnt = 0;
      e.tck = 1'b1;
      m_led = ~m_led;
    end else begin
      m_tcnt = m_tcnt + 1;
    end
    e.lng  = lng;
    e.rate = m_rate;
    e.led  = m_led;
  endtask

  // One clock: drive key, push expectation, sample after the edge and compare
  task automatic step(input logic k);
    exp_t e, got;
    key_state = k;
    model_step(k, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = {press_pulse, release_pulse, long_pulse, rate_sel, tick, led};
    e = sb_q.pop_front();
    check("scoreboard", int'(got), int'(e));
    n_press += int'(press_pulse);
    n_rel   += int'(release_pulse);
    n_long  += int'(long_pulse);
    n_tick  += int'(tick);
  endtask

  task automatic clear_tallies();
    n_press = 0; n_rel = 0; n_long = 0; n_tick = 0;
  endtask

  // Steps until the DUT ticks; -1 if the bound runs out
  task automatic cycles_to_tick(input logic k, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step(k);
      if (tick) begin n = i; break; end
    end
  endtask

  task automatic short_press();
    step(1'b1);
    step(1'b0);
    step(1'b0);
  endtask

  vec_t vecs[9];
  int   first_tick;
  int   n;

  initial begin
    vecs[0] = '{3, 2'd1, 0};
    vecs[1] = '{3, 2'd2, 0};
    vecs[2] = '{20, 2'd0, 1};
    vecs[3] = '{8, 2'd1, 0};   // released exactly when the hold count reaches 7
    vecs[4] = '{9, 2'd0, 1};
    vecs[5] = '{1, 2'd1, 0};
    vecs[6] = '{1, 2'd2, 0};
    vecs[7] = '{1, 2'd3, 0};
    vecs[8] = '{1, 2'd0, 0};

    model_reset();
    #3;
    check("reset_outputs", int'({press_pulse, release_pulse, long_pulse, rate_sel, tick, led}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle: tick every 4 cycles, first on the 4th edge
    clear_tallies();
    first_tick = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      if (tick && first_tick == 0) first_tick = i;
    end
    check("idle_first_tick", first_tick, 4);
    check("idle_tick_count", n_tick, 10);
    check("idle_led", int'(led), 0);
    check("idle_rate", int'(rate_sel), 0);

    foreach (vecs[v]) begin
      clear_tallies();
      for (int i = 0; i < vecs[v].press_len; i++) step(1'b1);
      for (int i = 0; i < 12; i++) step(1'b0);
      check($sformatf("vec%0d_rate", v), int'(rate_sel), int'(vecs[v].exp_rate));
      check($sformatf("vec%0d_press", v), n_press, 1);
      check($sformatf("vec%0d_release", v), n_rel, 1);
      check($sformatf("vec%0d_long", v), n_long, vecs[v].exp_long);
    end

    // Short press 0->1: first tick a full DIV1 after the change edge
    step(1'b1);
    step(1'b0);
    check("short_rate", int'(rate_sel), 1);
    cycles_to_tick(1'b0, n);
    check("short_next_tick", n, int'(D1));

    // Back to rate 0, then a long press must still restart the tick period
    short_press(); short_press(); short_press();
    check("wrap_rate", int'(rate_sel), 0);
    step(1'b0); step(1'b0);
    for (int i = 0; i < int'(LONG); i++) step(1'b1);
    check("no_early_long", int'(long_pulse), 0);
    step(1'b1);
    check("long_at_8", int'(long_pulse), 1);
    cycles_to_tick(1'b1, n);
    check("long_next_tick", n, int'(D0));
    for (int i = 0; i < 4; i++) step(1'b0);

    // Rate 3 with led high, then reset mid-hold
    short_press(); short_press(); short_press();
    n = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      if (tick && led) begin n = i; break; end
    end
    check("led_high_found", int'(n >= 0), 1);
    step(1'b1); step(1'b1); step(1'b1);
    check("pre_reset_rate", int'(rate_sel), 3);
    check("pre_reset_led", int'(led), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({press_pulse, release_pulse, long_pulse, rate_sel, tick, led}), 0);
    @(posedge clk); #1;
    check("reset_held_outputs", int'({press_pulse, release_pulse, long_pulse, rate_sel, tick, led}), 0);
    rst_n = 1'b1;
    model_reset();
    step(1'b1);
    check("post_reset_press", int'(press_pulse), 1);
    check("post_reset_rate", int'(rate_sel), 0);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 6; i++) step(1'b0);
    check("post_reset_short_rate", int'(rate_sel), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
